// File: rtl/vgc_irq_ctrl_if.sv
// CPU soft-switch bus for the VGC interrupt block.
// An access is one cycle with strobe & cen high. rw=1 reads and rw=0 writes.
// Read data appears on dout on the clock edge after the access and holds until the next decoded read.
// There is no back-pressure, so every access completes in that one cycle.
interface vgc_irq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              cen;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic              strobe;
  logic [7:0]        din;
  logic [7:0]        dout;

  modport master (output cen, addr, rw, strobe, din, input dout);
  modport slave  (input cen, addr, rw, strobe, din, output dout);
endinterface

// File: rtl/vgc_irq_ctrl.sv
// VGC interrupt latch/enable block that sits after the RTC/PRAM unit.
// It latches the one-second, quarter-second, VBL and optional scanline events.
// It exposes the $C023 VGCINT, $C032 SCANINT, $C041 INTEN, $C046 INTFLAG and $C047 CLRVBLINT soft switches.
// It drives the registered, active-low level IRQ to the 65816.
// Optional feature macro: VGC_SCANLINE_IRQ_EN (scanline port and sl_st/sl_en bits).
module vgc_irq_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                 CLK_14M,
  input  logic                 reset_n,
  vgc_irq_ctrl_if.slave        bus,
  input  logic                 onesec_pulse,
  input  logic                 qtrsec_pulse,
  input  logic                 vbl,
`ifdef VGC_SCANLINE_IRQ_EN
  input  logic                 scanline_irq,
`endif
  output logic                 irq_n
);

  localparam logic [ADDR_W-1:0] A_VGCINT  = ADDR_W'('h23);
  localparam logic [ADDR_W-1:0] A_SCANINT = ADDR_W'('h32);
  localparam logic [ADDR_W-1:0] A_INTEN   = ADDR_W'('h41);
  localparam logic [ADDR_W-1:0] A_INTFLAG = ADDR_W'('h46);
  localparam logic [ADDR_W-1:0] A_CLRVBL  = ADDR_W'('h47);

  logic       access, rd_acc, wr_acc;
  logic       vbl_d, vbl_ev;
  logic       os_st, qs_st, vb_st, sl_st;
  logic       os_en, sl_en;
  logic [7:0] inten;
  logic       qs_en, vb_en;
  logic       vgc_any, irq_any;
  logic       clr_os, clr_sl, clr_vq;
  logic [7:0] dout_q;

  assign access = bus.strobe & bus.cen;
  assign rd_acc = access & bus.rw;
  assign wr_acc = access & ~bus.rw;

  assign vbl_ev = vbl & ~vbl_d;
  assign qs_en  = inten[4];
  assign vb_en  = inten[3];

  // Clear requests: a 0 in $C032 bit 6/5 clears; any $C047 access clears both VBL-side flags.
  assign clr_os = wr_acc & (bus.addr == A_SCANINT) & ~bus.din[6];
  assign clr_sl = wr_acc & (bus.addr == A_SCANINT) & ~bus.din[5];
  assign clr_vq = access & (bus.addr == A_CLRVBL);

  assign vgc_any = (os_st & os_en) | (sl_st & sl_en);
  assign irq_any = vgc_any | (qs_st & qs_en) | (vb_st & vb_en);

  // VBL edge detector and the always-present status/enable registers.
  // A set event takes priority over a clear that arrives in the same cycle.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      vbl_d <= 1'b0;
      os_st <= 1'b0;
      qs_st <= 1'b0;
      vb_st <= 1'b0;
      os_en <= 1'b0;
      inten <= 8'h00;
    end else begin
      vbl_d <= vbl;
      if (onesec_pulse && os_en)      os_st <= 1'b1;
      else if (clr_os)                os_st <= 1'b0;
      if (qtrsec_pulse && qs_en)      qs_st <= 1'b1;
      else if (clr_vq)                qs_st <= 1'b0;
      if (vbl_ev && vb_en)            vb_st <= 1'b1;
      else if (clr_vq)                vb_st <= 1'b0;
      if (wr_acc && bus.addr == A_VGCINT) os_en <= bus.din[2];
      if (wr_acc && bus.addr == A_INTEN)  inten <= bus.din;
    end
  end

`ifdef VGC_SCANLINE_IRQ_EN
  // Scanline status/enable, same set-wins rule as the other sources.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      sl_st <= 1'b0;
      sl_en <= 1'b0;
    end else begin
      if (scanline_irq && sl_en)      sl_st <= 1'b1;
      else if (clr_sl)                sl_st <= 1'b0;
      if (wr_acc && bus.addr == A_VGCINT) sl_en <= bus.din[1];
    end
  end
`else
  // Without the scanline source the bits are tied off and the clear request goes nowhere.
  assign sl_st = 1'b0;
  assign sl_en = 1'b0;
  logic unused_clr_sl;
  assign unused_clr_sl = clr_sl;
`endif

  // Registered read data; undecoded or write accesses leave dout untouched.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= 8'h00;
    end else if (rd_acc) begin
      case (bus.addr)
        A_VGCINT:  dout_q <= {vgc_any, os_st, sl_st, 2'b00, os_en, sl_en, 1'b0};
        A_SCANINT: dout_q <= 8'h00;
        A_INTEN:   dout_q <= inten;
        A_INTFLAG: dout_q <= {3'b000, qs_st, vb_st, 3'b000};
        A_CLRVBL:  dout_q <= 8'h00;
        default:   dout_q <= dout_q;
      endcase
    end
  end

  assign bus.dout = dout_q;

  // Level IRQ, registered one cycle behind the status/enable state.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) irq_n <= 1'b1;
    else          irq_n <= ~irq_any;
  end

endmodule

// File: tb/tb_vgc_irq_ctrl.sv
// Directed bench for vgc_irq_ctrl with hand-computed expected values.
module tb_vgc_irq_ctrl;

  logic CLK_14M = 1'b0;
  logic reset_n = 1'b0;
  logic onesec_pulse = 1'b0;
  logic qtrsec_pulse = 1'b0;
  logic vbl = 1'b0;
  logic scanline_irq = 1'b0;
  logic irq_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] rdata;

  vgc_irq_ctrl_if #(.ADDR_W(8)) bus ();

  vgc_irq_ctrl #(.ADDR_W(8)) dut (
    .CLK_14M      (CLK_14M),
    .reset_n      (reset_n),
    .bus          (bus),
    .onesec_pulse (onesec_pulse),
    .qtrsec_pulse (qtrsec_pulse),
    .vbl          (vbl),
`ifdef VGC_SCANLINE_IRQ_EN
    .scanline_irq (scanline_irq),
`endif
    .irq_n        (irq_n)
  );

  // Clock and reset block.
  always #5 CLK_14M = ~CLK_14M;

  task automatic step();
    @(posedge CLK_14M);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.cen = 1'b1; bus.strobe = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.din = d;
    step();
    bus.strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.cen = 1'b1; bus.strobe = 1'b1; bus.rw = 1'b1; bus.addr = a;
    step();
    bus.strobe = 1'b0;
    d = bus.dout;
  endtask

  task automatic pulse_os();
    onesec_pulse = 1'b1; step(); onesec_pulse = 1'b0;
  endtask

  task automatic pulse_qs();
    qtrsec_pulse = 1'b1; step(); qtrsec_pulse = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_sl_rd;
    logic       exp_sl_irq;
    bus.cen = 1'b1; bus.strobe = 1'b0; bus.rw = 1'b1; bus.addr = 8'h00; bus.din = 8'h00;

    // Reset state
    repeat (3) step();
    check("rst_irq_n", {7'd0, irq_n}, 8'h01);
    check("rst_dout", bus.dout, 8'h00);
    reset_n = 1'b1;
    step();
    rd(8'h23, rdata); check("rst_c023", rdata, 8'h00);
    rd(8'h41, rdata); check("rst_c041", rdata, 8'h00);
    rd(8'h46, rdata); check("rst_c046", rdata, 8'h00);

    // One-second source
    wr(8'h23, 8'h04);
    pulse_os();
    check("os_irq_lat0", {7'd0, irq_n}, 8'h01);
    step();
    check("os_irq_lat1", {7'd0, irq_n}, 8'h00);
    rd(8'h23, rdata); check("os_c023", rdata, 8'hC4);
    wr(8'h32, 8'hBF);
    rd(8'h23, rdata); check("os_c023_clr", rdata, 8'h04);
    check("os_irq_clr", {7'd0, irq_n}, 8'h01);
    rd(8'h32, rdata); check("c032_read", rdata, 8'h00);

    // Disabling keeps the pending status bit
    pulse_os();
    wr(8'h23, 8'h00);
    rd(8'h23, rdata); check("os_disabled_pend", rdata, 8'h40);
    check("os_disabled_irq", {7'd0, irq_n}, 8'h01);
    wr(8'h32, 8'h00);
    rd(8'h23, rdata); check("os_cleared", rdata, 8'h00);

    // Quarter-second and VBL sources
    wr(8'h41, 8'h18);
    pulse_qs();
    vbl = 1'b1; step();
    rd(8'h46, rdata); check("qv_c046", rdata, 8'h18);
    check("qv_irq", {7'd0, irq_n}, 8'h00);
    rd(8'h47, rdata); check("c047_read", rdata, 8'h00);
    rd(8'h46, rdata); check("qv_c046_clr", rdata, 8'h00);
    check("qv_irq_clr", {7'd0, irq_n}, 8'h01);
    rd(8'h41, rdata); check("c041_rb", rdata, 8'h18);
    wr(8'h46, 8'hFF);
    rd(8'h46, rdata); check("c046_wr_ignored", rdata, 8'h00);

    // Masked sources set nothing
    vbl = 1'b0; step();
    wr(8'h41, 8'h00);
    pulse_qs();
    vbl = 1'b1; step();
    rd(8'h46, rdata); check("mask_c046", rdata, 8'h00);
    check("mask_irq", {7'd0, irq_n}, 8'h01);
    wr(8'h41, 8'h18);
    repeat (100) step();
    rd(8'h46, rdata); check("vbl_level_c046", rdata, 8'h00);
    check("vbl_level_irq", {7'd0, irq_n}, 8'h01);
    vbl = 1'b0; step();

    // A write to $C047 also clears
    pulse_qs(); step();
    check("qs_irq", {7'd0, irq_n}, 8'h00);
    wr(8'h47, 8'h00);
    rd(8'h46, rdata); check("c047_wr_clr", rdata, 8'h00);

    // Set beats clear in the same cycle
    wr(8'h23, 8'h04);
    bus.strobe = 1'b1; bus.rw = 1'b0; bus.addr = 8'h32; bus.din = 8'h00;
    onesec_pulse = 1'b1;
    step();
    bus.strobe = 1'b0; onesec_pulse = 1'b0;
    rd(8'h23, rdata); check("race_c023", rdata, 8'hC4);
    wr(8'h32, 8'h00);
    wr(8'h23, 8'h00);

    // cen low blocks the access; undecoded reads hold dout
    bus.cen = 1'b0; bus.strobe = 1'b1; bus.rw = 1'b0; bus.addr = 8'h41; bus.din = 8'hFF;
    step();
    bus.strobe = 1'b0; bus.cen = 1'b1;
    rd(8'h41, rdata); check("cen_gate", rdata, 8'h18);
    rd(8'h55, rdata); check("undecoded_hold", rdata, 8'h18);

    // Scanline source
`ifdef VGC_SCANLINE_IRQ_EN
    exp_sl_rd = 8'hA2; exp_sl_irq = 1'b0;
`else
    exp_sl_rd = 8'h00; exp_sl_irq = 1'b1;
`endif
    wr(8'h23, 8'h02);
    scanline_irq = 1'b1; step(); scanline_irq = 1'b0;
    step();
    rd(8'h23, rdata); check("sl_c023", rdata, exp_sl_rd);
    check("sl_irq", {7'd0, irq_n}, {7'd0, exp_sl_irq});
    wr(8'h32, 8'h00);
    wr(8'h23, 8'h00);

    // Reset in the middle of an access with an interrupt pending
    pulse_qs(); step();
    rd(8'h41, rdata);
    check("pre_rst_irq", {7'd0, irq_n}, 8'h00);
    bus.strobe = 1'b1; bus.rw = 1'b0; bus.addr = 8'h41; bus.din = 8'hFF;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_irq", {7'd0, irq_n}, 8'h01);
    check("mid_rst_dout", bus.dout, 8'h00);
    step();
    bus.strobe = 1'b0;
    reset_n = 1'b1;
    step();
    rd(8'h23, rdata); check("post_rst_c023", rdata, 8'h00);
    rd(8'h41, rdata); check("post_rst_c041", rdata, 8'h00);
    rd(8'h46, rdata); check("post_rst_c046", rdata, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
